// File: rtl/snk_ioctl_loader_pkg.sv
// Shared types for the ioctl ROM-download loader: FSM states, FIFO word
// layout and the byte-lane selection helper.
package snk_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    GAP
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } loader_word_t;

  // Big-endian order walks lanes 3..0, little-endian walks lanes 0..3.
  function automatic logic [7:0] select_byte(input logic [31:0] data,
                                             input logic [1:0]  idx,
                                             input bit          big_endian);
    logic [1:0] lane;
    lane = big_endian ? ~idx : idx;
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/snk_ioctl_loader_if.sv
// Bridge-side word writes and core-side ioctl byte writes of the loader.
interface snk_ioctl_loader_if;

  logic        dl_active;
  logic        bridge_wr;
  logic [24:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        word_ready;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        dl_done;
  logic        overflow;

  modport master (
    output dl_active, bridge_wr, bridge_addr, bridge_wr_data,
    input  word_ready, ioctl_addr, ioctl_data, ioctl_wr,
           ioctl_download, dl_done, overflow
  );

  modport slave (
    input  dl_active, bridge_wr, bridge_addr, bridge_wr_data,
    output word_ready, ioctl_addr, ioctl_data, ioctl_wr,
           ioctl_download, dl_done, overflow
  );

endinterface

// File: rtl/snk_ioctl_loader_fifo.sv
// Synchronous word FIFO for the loader; supports push and pop in the same
// cycle, including push while full when a pop frees the slot.
module snk_loader_fifo
  import snk_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  loader_word_t wr_word,
  output loader_word_t rd_word,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  loader_word_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/snk_ioctl_loader.sv
// Buffers 32-bit bridge words and serialises them into paced single-byte
// ioctl writes for the SNK core ROM download path.
module snk_ioctl_loader
  import snk_loader_pkg::*;
#(
  parameter int unsigned WRITE_GAP  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic               i_clk,
  input logic               reset,
  snk_ioctl_loader_if.slave bus
);

  localparam logic [7:0] GAP_INIT = 8'(WRITE_GAP - 1);
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  loader_state_t state, state_next;
  logic [1:0]    byte_idx, byte_idx_next;
  logic [7:0]    gap_cnt, gap_cnt_next;
  loader_word_t  cur_word, cur_word_next;

  logic          pop;
  logic          push;
  logic          drop;
  logic          busy;
  logic          fifo_full;
  logic          fifo_empty;
  loader_word_t  fifo_word;
  loader_word_t  in_word;

  assign in_word.addr = bus.bridge_addr[24:2];
  assign in_word.data = bus.bridge_wr_data;

  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign push = bus.bridge_wr && (!fifo_full || pop);
  assign drop = bus.bridge_wr && fifo_full && !pop;
  assign busy = bus.dl_active || !fifo_empty || (state != IDLE);

  assign bus.word_ready = !fifo_full;

  snk_loader_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_word (in_word),
    .rd_word (fifo_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      gap_cnt  <= '0;
      cur_word <= '0;
    end else begin
      state    <= state_next;
      byte_idx <= byte_idx_next;
      gap_cnt  <= gap_cnt_next;
      cur_word <= cur_word_next;
    end
  end

  always_comb begin
    logic decide;
    state_next    = state;
    byte_idx_next = byte_idx;
    gap_cnt_next  = gap_cnt;
    cur_word_next = cur_word;
    pop           = 1'b0;
    decide        = 1'b0;

    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          cur_word_next = fifo_word;
          byte_idx_next = '0;
          state_next    = EMIT;
        end
      end
      EMIT: begin
        if (WRITE_GAP == 1) begin
          decide = 1'b1;
        end else begin
          state_next   = GAP;
          gap_cnt_next = GAP_INIT;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt - 8'd1;
        if (gap_cnt == 8'd1) decide = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Shared by EMIT (gap of 1) and the final GAP cycle so pacing holds
    // across word boundaries.
    if (decide) begin
      if (byte_idx != LAST_IDX) begin
        byte_idx_next = byte_idx + 2'd1;
        state_next    = EMIT;
      end else if (!fifo_empty) begin
        pop           = 1'b1;
        cur_word_next = fifo_word;
        byte_idx_next = '0;
        state_next    = EMIT;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      bus.ioctl_wr       <= 1'b0;
      bus.ioctl_addr     <= '0;
      bus.ioctl_data     <= '0;
      bus.ioctl_download <= 1'b0;
      bus.dl_done        <= 1'b0;
      bus.overflow       <= 1'b0;
    end else begin
      bus.ioctl_wr <= (state == EMIT);
      if (state == EMIT) begin
        bus.ioctl_addr <= {cur_word.addr, byte_idx};
        bus.ioctl_data <= select_byte(cur_word.data, byte_idx, BIG_ENDIAN);
      end
      bus.ioctl_download <= busy;
      bus.dl_done        <= bus.ioctl_download && !busy;
      if (drop) bus.overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snk_ioctl_loader.sv
// Three loader configurations share one stimulus stream; each has a
// timeline-level reference model feeding a scoreboard checked by a monitor.
module tb_snk_ioctl_loader;
  import snk_loader_pkg::*;

  typedef struct {
    int unsigned at;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_active;
  logic        bridge_wr;
  logic [24:0] bridge_addr;
  logic [31:0] bridge_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  bit win_on = 1'b0;
  int win_wr = 0;
  int win_done = 0;
  int win_wr_at_done = -1;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned inst,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int unsigned G  = (k == 2) ? 1 : 4;
    localparam int unsigned D  = (k == 2) ? 2 : 4;
    localparam bit          BE = (k != 1);

    snk_ioctl_loader_if bus ();

    assign bus.dl_active      = dl_active;
    assign bus.bridge_wr      = bridge_wr;
    assign bus.bridge_addr    = bridge_addr;
    assign bus.bridge_wr_data = bridge_wr_data;

    snk_ioctl_loader #(
      .WRITE_GAP  (G),
      .FIFO_DEPTH (D),
      .BIG_ENDIAN (BE)
    ) dut (
      .i_clk (clk),
      .reset (rst),
      .bus   (bus)
    );

    loader_word_t fq[$];
    exp_t         eq[$];
    int unsigned  edge_n = 0;
    int unsigned  ready = 0;
    bit           ovf_m = 1'b0;
    bit           eng_busy = 1'b0;
    bit           dl_m = 1'b0;
    bit           done_m = 1'b0;

    // A word may leave the FIFO once 4*G edges have passed since the
    // previous one; its bytes appear at pop+1, pop+1+G, ...
    always @(posedge clk) begin : model
      bit pop, push, busy;
      loader_word_t w;
      exp_t e;
      edge_n++;
      if (rst) begin
        fq.delete();
        eq.delete();
        ready = 0;
        ovf_m = 1'b0;
        eng_busy = 1'b0;
        dl_m = 1'b0;
        done_m = 1'b0;
      end else begin
        busy   = dl_active || (fq.size() != 0) || eng_busy;
        done_m = dl_m && !busy;
        dl_m   = busy;
        pop  = (fq.size() != 0) && (edge_n >= ready);
        push = bridge_wr && ((fq.size() < D) || pop);
        if (bridge_wr && !push) ovf_m = 1'b1;
        if (pop) begin
          w = fq.pop_front();
          ready = edge_n + 4 * G;
          for (int unsigned b = 0; b < 4; b++) begin
            e.at   = edge_n + 1 + b * G;
            e.addr = {w.addr, 2'(b)};
            e.data = BE ? 8'(w.data >> (24 - 8 * b)) : 8'(w.data >> (8 * b));
            eq.push_back(e);
          end
        end
        if (push) fq.push_back('{bridge_addr[24:2], bridge_wr_data});
        eng_busy = pop || (edge_n < ready);
      end
    end

    always @(negedge clk) begin : monitor
      bit exp_wr;
      exp_t e;
      exp_wr = (eq.size() != 0) && (eq[0].at == edge_n);
      chk("ioctl_wr", k, 64'(bus.ioctl_wr), 64'(exp_wr));
      if (exp_wr) begin
        e = eq.pop_front();
        if (bus.ioctl_wr === 1'b1) begin
          chk("ioctl_addr", k, 64'(bus.ioctl_addr), 64'(e.addr));
          chk("ioctl_data", k, 64'(bus.ioctl_data), 64'(e.data));
        end
      end
      chk("word_ready", k, 64'(bus.word_ready), 64'(fq.size() < D));
      chk("overflow", k, 64'(bus.overflow), 64'(ovf_m));
      chk("ioctl_download", k, 64'(bus.ioctl_download), 64'(dl_m));
      chk("dl_done", k, 64'(bus.dl_done), 64'(done_m));
    end
  end

  always @(negedge clk) begin
    if (win_on) begin
      if (g_inst[0].bus.ioctl_wr === 1'b1) win_wr++;
      if (g_inst[0].bus.dl_done === 1'b1) begin
        win_done++;
        win_wr_at_done = win_wr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [24:0] a, input logic [31:0] d);
    bridge_wr      = 1'b1;
    bridge_addr    = a;
    bridge_wr_data = d;
    tick();
    bridge_wr = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    dl_active = 1'b0;
    bridge_wr = 1'b0;
    bridge_addr = '0;
    bridge_wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    dl_active = 1'b1;
    push(25'h000100, 32'hAABBCCDD);
    dl_active = 1'b0;
    repeat (40) tick();

    for (int unsigned i = 0; i < 6; i++) push(25'(4 * i), $urandom);
    repeat (120) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    push(25'h002000, 32'h11223344);
    repeat (40) tick();

    push(25'h000010, $urandom);
    push(25'h000080, $urandom);
    repeat (60) tick();

    // Reset after the second byte of a word with two more words queued.
    for (int unsigned i = 0; i < 3; i++) push(25'(32'h300 + 4 * i), $urandom);
    seen = 0;
    for (int c = 0; c < 60 && seen < 2; c++) begin
      @(negedge clk);
      if (g_inst[0].bus.ioctl_wr === 1'b1) seen++;
    end
    chk("wait_two_writes", 0, 64'(seen), 64'd2);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (30) tick();

    win_on = 1'b1;
    dl_active = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c == 5 || c == 40 || c == 70) push(25'($urandom), $urandom);
      else tick();
    end
    dl_active = 1'b0;
    repeat (60) tick();
    win_on = 1'b0;
    chk("window_dl_done_pulses", 0, 64'(win_done), 64'd1);
    chk("window_writes_before_done", 0, 64'(win_wr_at_done), 64'd12);

    for (int c = 0; c < 400; c++) begin
      bridge_wr      = ($urandom_range(2) == 0);
      bridge_addr    = 25'($urandom);
      bridge_wr_data = $urandom;
      if ($urandom_range(19) == 0) dl_active = ~dl_active;
      rst = ($urandom_range(149) == 0);
      tick();
    end
    bridge_wr = 1'b0;
    dl_active = 1'b0;
    rst = 1'b0;
    repeat (150) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
